// File: rtl/fifo_read_drainer.sv
// Read-side drainer for the memory core in FIFO mode: mirrors occupancy, issues ren, buffers read data.
// Latency: ren_out -> core data -> skid push is 2 edges; out_data is the registered head of the skid.
// Backpressure: out_rdy low fills the 2-entry skid; ren_out is withheld once skid + in-flight reach 2.
module fifo_read_drainer #(
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 16,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               flush,
    input  logic [DEPTH_W-1:0] depth,
    input  logic [TMO_W-1:0]   timeout_limit,
    input  logic               wen_in,
    output logic               ren_out,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               valid_in,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_rdy,
    output logic [DEPTH_W-1:0] occupancy,
    output logic               empty,
    output logic               full,
    output logic [3:0]         err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_BLOCKED = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DEPTH_W-1:0]  occ_q, occ_d;
    logic                inflight_q, inflight_d;
    logic [DATA_W-1:0]   skid0_q, skid0_d;
    logic [DATA_W-1:0]   skid1_q, skid1_d;
    logic [1:0]          skid_cnt_q, skid_cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [3:0]          err_q, err_d;

    logic                pop;
    logic [2:0]          credit_used;
    logic                credit_ok;
    logic                ren;
    logic                push;
    logic                missing;
    logic                spurious;
    logic                wr_inc;
    logic                rd_dec;
    logic                ovf;
    logic [TMO_W-1:0]    tmo_next;
    logic                tmo_hit;
    logic [3:0]          err_set;

    // out_rdy only counts while the block is enabled, so a gated clock freezes the skid
    assign pop         = clk_en & (skid_cnt_q != 2'd0) & out_rdy;
    assign credit_used = {1'b0, skid_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok   = (credit_used < 3'd2);
    assign ren         = clk_en & (state_q == ST_ACTIVE) & (occ_q != '0) & credit_ok;

    assign push     = inflight_q & valid_in;
    assign missing  = inflight_q & ~valid_in;
    assign spurious = ~inflight_q & valid_in;

    assign wr_inc = wen_in & ~ren;
    assign rd_dec = ren & ~wen_in;
    assign ovf    = wr_inc & (occ_q == depth);

    always_comb begin
        tmo_next = tmo_q;
        tmo_hit  = 1'b0;
        if ((occ_q == '0) || ren) begin
            tmo_next = '0;
        end else if ((timeout_limit != '0) && (tmo_q >= timeout_limit)) begin
            tmo_next = tmo_q;
        end else if (tmo_q != '1) begin
            tmo_next = tmo_q + TMO_W'(1);
        end
        tmo_hit = (timeout_limit != '0) && (tmo_next >= timeout_limit);
    end

    assign err_set = {tmo_hit, ovf, missing, spurious};

    always_comb begin
        occ_d      = occ_q;
        inflight_d = inflight_q;
        skid0_d    = skid0_q;
        skid1_d    = skid1_q;
        skid_cnt_d = skid_cnt_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        state_d    = state_q;

        if (clk_en) begin
            if (flush) begin
                occ_d      = '0;
                inflight_d = 1'b0;
                skid0_d    = '0;
                skid1_d    = '0;
                skid_cnt_d = 2'd0;
                tmo_d      = '0;
                err_d      = '0;
                state_d    = ST_IDLE;
            end else begin
                if (wr_inc && !ovf) begin
                    occ_d = occ_q + DEPTH_W'(1);
                end else if (rd_dec) begin
                    occ_d = occ_q - DEPTH_W'(1);
                end

                inflight_d = ren;
                tmo_d      = tmo_next;
                err_d      = err_q | err_set;

                case ({push, pop})
                    2'b10: begin
                        if (skid_cnt_q == 2'd0) begin
                            skid0_d    = data_in;
                            skid_cnt_d = 2'd1;
                        end else if (skid_cnt_q == 2'd1) begin
                            skid1_d    = data_in;
                            skid_cnt_d = 2'd2;
                        end
                    end
                    2'b01: begin
                        skid0_d    = skid1_q;
                        skid_cnt_d = skid_cnt_q - 2'd1;
                    end
                    2'b11: begin
                        if (skid_cnt_q == 2'd1) begin
                            skid0_d = data_in;
                        end else begin
                            skid0_d = skid1_q;
                            skid1_d = data_in;
                        end
                    end
                    default: ;
                endcase

                if (err_set != 4'd0) begin
                    state_d = ST_ERROR;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (occ_d != '0) state_d = ST_ACTIVE;
                        end
                        ST_ACTIVE: begin
                            if ((occ_q != '0) && !credit_ok) begin
                                state_d = ST_BLOCKED;
                            end else if ((occ_d == '0) && (skid_cnt_q == 2'd0) && !inflight_q) begin
                                state_d = ST_IDLE;
                            end
                        end
                        ST_BLOCKED: begin
                            if (pop) state_d = ST_ACTIVE;
                        end
                        default: state_d = ST_ERROR;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            skid0_q    <= '0;
            skid1_q    <= '0;
            skid_cnt_q <= 2'd0;
            tmo_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            skid0_q    <= skid0_d;
            skid1_q    <= skid1_d;
            skid_cnt_q <= skid_cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    assign ren_out   = ren;
    assign out_data  = skid0_q;
    assign out_valid = (skid_cnt_q != 2'd0);
    assign occupancy = occ_q;
    assign empty     = (occ_q == '0);
    assign full      = (occ_q == depth);
    assign err       = err_q;

endmodule

// File: tb/tb_fifo_read_drainer.sv
// Scoreboard bench for fifo_read_drainer: a core model answers ren_out one cycle later,
// expected words are queued at write time and popped by a monitor on every accepted output.
module tb_fifo_read_drainer;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        flush;
    logic [15:0] depth;
    logic [15:0] timeout_limit;
    logic        wen_in;
    logic        ren_out;
    logic [15:0] data_in;
    logic        valid_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_rdy;
    logic [15:0] occupancy;
    logic        empty;
    logic        full;
    logic [3:0]  err;

    logic [15:0] exp_q[$];
    logic [15:0] core_q[$];
    int          total = 0;
    int          passed = 0;
    int          ren_cnt = 0;
    int          r0;
    bit          core_manual = 1'b0;
    bit          suppress_valid = 1'b0;

    always #5 clk = ~clk;

    fifo_read_drainer #(.DATA_W(16), .DEPTH_W(16), .TMO_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .flush        (flush),
        .depth        (depth),
        .timeout_limit(timeout_limit),
        .wen_in       (wen_in),
        .ren_out      (ren_out),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_rdy      (out_rdy),
        .occupancy    (occupancy),
        .empty        (empty),
        .full         (full),
        .err          (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && ren_out) ren_cnt++;
    end

    // Core model: data for a read request appears exactly one cycle later
    initial begin
        logic r;
        forever begin
            @(negedge clk);
            r = ren_out;
            @(posedge clk);
            #1;
            if (!core_manual) begin
                if (r && core_q.size() > 0) begin
                    data_in  = core_q.pop_front();
                    valid_in = !suppress_valid;
                end else begin
                    data_in  = '0;
                    valid_in = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && clk_en && out_valid && out_rdy) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_output: got 0x%0h, required no output", out_data);
            end else begin
                check("out_data", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset(input logic [15:0] dep, input logic [15:0] lim);
        reset          = 1'b0;
        depth          = dep;
        timeout_limit  = lim;
        wen_in         = 1'b0;
        flush          = 1'b0;
        out_rdy        = 1'b0;
        clk_en         = 1'b1;
        core_manual    = 1'b0;
        suppress_valid = 1'b0;
        exp_q.delete();
        core_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic write_n(input int n, input logic [15:0] base, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            wen_in = 1'b1;
            core_q.push_back(base + 16'(i));
            if (expect_out) exp_q.push_back(base + 16'(i));
            tick();
        end
        wen_in = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clk_en = 1'b1; flush = 1'b0; depth = 16'd4; timeout_limit = 16'd0;
        wen_in = 1'b0; data_in = '0; valid_in = 1'b0; out_rdy = 1'b0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ren_out", ren_out, 0);
        reset = 1'b1;
        tick();

        // Three words, downstream always ready
        out_rdy = 1'b1;
        r0 = ren_cnt;
        write_n(3, 16'hA000, 1'b1);
        repeat (12) tick();
        check("t1_ren_count", ren_cnt - r0, 3);
        check("t1_occupancy", occupancy, 0);
        check("t1_err", err, 0);
        check("t1_state_idle", 32'(dut.state_q), 0);
        check("t1_drained", exp_q.size(), 0);

        // Four words with downstream stalled: two reads fill the skid, then blocked
        do_reset(16'd4, 16'd0);
        r0 = ren_cnt;
        write_n(4, 16'hB000, 1'b1);
        repeat (6) tick();
        check("t2_ren_count", ren_cnt - r0, 2);
        check("t2_occupancy", occupancy, 2);
        check("t2_state_blocked", 32'(dut.state_q), 2);
        check("t2_head", out_data, 16'hB000);
        clk_en  = 1'b0;
        out_rdy = 1'b1;
        repeat (3) tick();
        check("t2_gated_head", out_data, 16'hB000);
        check("t2_gated_ren", ren_cnt - r0, 2);
        check("t2_gated_valid", out_valid, 1);
        clk_en = 1'b1;
        repeat (15) tick();
        check("t2_ren_total", ren_cnt - r0, 4);
        check("t2_occupancy_end", occupancy, 0);
        check("t2_err", err, 0);
        check("t2_drained", exp_q.size(), 0);

        // Overflow: depth 2 already full, one more write
        do_reset(16'd2, 16'd0);
        r0 = ren_cnt;
        write_n(4, 16'hC000, 1'b1);
        check("t3_full_before", full, 1);
        wen_in = 1'b1;
        tick();
        wen_in = 1'b0;
        check("t3_err", err, 4'b0100);
        check("t3_occupancy", occupancy, 2);
        check("t3_state_error", 32'(dut.state_q), 3);
        check("t3_ren_out", ren_out, 0);
        out_rdy = 1'b1;
        repeat (6) tick();
        check("t3_ren_count", ren_cnt - r0, 2);
        check("t3_pending", exp_q.size(), 2);
        check("t3_out_valid", out_valid, 0);

        // Spurious valid, flush, then missing valid
        do_reset(16'd4, 16'd0);
        core_manual = 1'b1;
        valid_in = 1'b1;
        data_in  = 16'hDEAD;
        tick();
        valid_in = 1'b0;
        data_in  = '0;
        tick();
        core_manual = 1'b0;
        check("t4_err_spurious", err, 4'b0001);
        check("t4_skid_unchanged", out_valid, 0);
        check("t4_occupancy", occupancy, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_err", err, 0);
        suppress_valid = 1'b1;
        out_rdy = 1'b1;
        write_n(1, 16'hE000, 1'b0);
        repeat (4) tick();
        check("t4_err_missing", err, 4'b0010);
        check("t4_missing_out_valid", out_valid, 0);
        check("t4_missing_occ", occupancy, 0);
        suppress_valid = 1'b0;

        // Drain timeout of 5 with skid full and one word stranded in the core
        do_reset(16'd4, 16'd5);
        write_n(3, 16'hF000, 1'b1);
        repeat (4) tick();
        check("t5_err_before", err, 0);
        check("t5_occupancy", occupancy, 1);
        tick();
        check("t5_err_timeout", err, 4'b1000);
        check("t5_skid_valid", out_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        core_q.delete();
        check("t5_flush_err", err, 0);
        check("t5_flush_occ", occupancy, 0);
        check("t5_flush_out_valid", out_valid, 0);
        check("t5_flush_empty", empty, 1);

        // Asynchronous reset mid-drain with a read in flight
        do_reset(16'd4, 16'd0);
        write_n(3, 16'h1000, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_out_valid", out_valid, 0);
        check("t6_out_data", out_data, 0);
        check("t6_err", err, 0);
        check("t6_occupancy", occupancy, 0);
        check("t6_ren_out", ren_out, 0);
        exp_q.delete();
        core_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        out_rdy = 1'b1;
        write_n(2, 16'h2000, 1'b1);
        repeat (10) tick();
        check("t6_post_drained", exp_q.size(), 0);
        check("t6_post_occ", occupancy, 0);
        check("t6_post_err", err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
